logicnet_input_quantizer: RTL

//  Front-end stage that feeds the layer-0 LUT neurons. Accepts raw signed features one per cycle over valid/ready.

---
 rtl/logicnet_pkg.sv | 13 +
 rtl/logicnet_feature_quant.sv | 27 ++
 rtl/logicnet_input_quantizer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/logicnet_pkg.sv
// Shared constants and types for the LogicNet input quantizer.
// Parameter defaults plus the derived threshold count per feature.
package logicnet_pkg;

  localparam int DEF_NUM_FEATURES = 32;
  localparam int DEF_IN_W         = 16;
  localparam int DEF_Q_BITS       = 2;
  localparam int DEF_NUM_THR      = 2**DEF_Q_BITS - 1;

  typedef logic signed [DEF_IN_W-1:0] thr_t;
  typedef logic [DEF_Q_BITS-1:0]      qval_t;

endpackage

// File: rtl/logicnet_feature_quant.sv
// Combinational quantiser for one feature: counts the thresholds that the
// signed input meets or exceeds, saturating at the top code.
module logicnet_feature_quant
  import logicnet_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int Q_BITS  = DEF_Q_BITS,
  parameter int NUM_THR = DEF_NUM_THR
) (
  input  logic signed [IN_W-1:0]         in_data,
  input  logic        [NUM_THR*IN_W-1:0] thr,
  output logic        [Q_BITS-1:0]       q
);

  localparam logic [Q_BITS:0] Q_MAX = (Q_BITS+1)'(2**Q_BITS - 1);

  logic [Q_BITS:0] hits;

  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_THR; i++) begin
      if (in_data >= $signed(thr[i*IN_W +: IN_W])) hits = hits + 1'b1;
    end
    q = (hits > Q_MAX) ? Q_MAX[Q_BITS-1:0] : hits[Q_BITS-1:0];
  end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Quantises a stream of signed features and packs each full vector for layer 0.
// Define LNET_INQ_DBUF_EN for separate assembly/output registers (double buffer).
module logicnet_input_quantizer
  import logicnet_pkg::*;
#(
  parameter  int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter  int IN_W         = DEF_IN_W,
  parameter  int Q_BITS       = DEF_Q_BITS,
  localparam int FIDX_W       = $clog2(NUM_FEATURES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [IN_W-1:0]         in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [NUM_FEATURES*Q_BITS-1:0] out_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           cfg_we,
  input  logic [FIDX_W-1:0]              cfg_feat,
  input  logic [Q_BITS-1:0]              cfg_idx,
  input  logic signed [IN_W-1:0]         cfg_data,
  output logic                           err_frame
);

  localparam int NUM_THR = 2**Q_BITS - 1;
  localparam int VEC_W   = NUM_FEATURES * Q_BITS;

  logic signed [IN_W-1:0] thr_q [NUM_FEATURES][NUM_THR];
  logic signed [IN_W-1:0] thr_d [NUM_FEATURES][NUM_THR];
  logic [NUM_THR*IN_W-1:0] thr_sel;
  logic [Q_BITS-1:0]       q;

  logic [FIDX_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0]  asm_q, asm_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              accept, last_slot, complete, bad_frame;

  // Threshold table: the top cfg_idx code has no threshold behind it and is dropped.
  always_comb begin
    thr_d = thr_q;
    if (cfg_we && cfg_idx != {Q_BITS{1'b1}}) thr_d[cfg_feat][cfg_idx] = cfg_data;
    thr_sel = '0;
    for (int i = 0; i < NUM_THR; i++) thr_sel[i*IN_W +: IN_W] = thr_q[cnt_q][i];
  end

  logicnet_feature_quant #(
    .IN_W    (IN_W),
    .Q_BITS  (Q_BITS),
    .NUM_THR (NUM_THR)
  ) u_quant (
    .in_data (in_data),
    .thr     (thr_sel),
    .q       (q)
  );

  assign accept    = in_valid && in_ready;
  assign last_slot = (cnt_q == FIDX_W'(NUM_FEATURES - 1));
  assign complete  = accept && in_last && last_slot;
  assign bad_frame = accept && (in_last != last_slot);

  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    err_d = err_q || bad_frame;
    if (accept) begin
      asm_d[cnt_q*Q_BITS +: Q_BITS] = q;
      cnt_d = (in_last || last_slot) ? '0 : cnt_q + 1'b1;
    end
  end

`ifdef LNET_INQ_DBUF_EN
  logic [VEC_W-1:0] out_q, out_d;
  logic             pend_q, pend_d;
  logic             xfer;

  assign xfer = out_valid_q && out_ready;

  // A completed vector that found the output busy is parked in asm_q (pend_q).
  always_comb begin
    out_d       = out_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q && !xfer;
    if (pend_q && !out_valid_q) begin
      out_d       = asm_q;
      out_valid_d = 1'b1;
      pend_d      = 1'b0;
    end else if (complete) begin
      if (!out_valid_q || xfer) begin
        out_d       = asm_d;
        out_valid_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      pend_q <= pend_d;
    end
  end

  assign in_ready = !pend_q;
  assign out_vec  = out_q;
`else
  always_comb begin
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (complete)                 out_valid_d = 1'b1;
  end

  assign in_ready = !out_valid_q;
  assign out_vec  = asm_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < NUM_FEATURES; f++) begin
        for (int i = 0; i < NUM_THR; i++) thr_q[f][i] <= '0;
      end
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign err_frame = err_q;

endmodule
